uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the next generation of the team's fixed 8N1 receiver.
- Runtime-independent frame format set by parameters: 5–9 data bits, none/odd/even parity, 1 or 2 stop bits.
- Input synchroniser plus majority glitch filter.
- Valid/ready output holding register, with parity, framing, break and overrun reporting.
- Sits between the board RX pin and the protocol/crypto command layer.

Parameters:
- CLK_FREQ, 100000000, system clock in Hz (documentation only).
- BAUD_DIV, 100, clock cycles per bit; legal range 16..65535; simulation default 100.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked: 1 or 2.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous, active-high reset.
- In_rx  in  1  serial line, idle high, asynchronous to Clk.
- In_ready  in  1  consumer accepts current word this cycle.
- Out_data  out  DATA_BITS  received word, LSB = first bit on the line.
- Out_data_vld  out  1  Out_data/flags valid; held until accepted.
- Out_parity_err  out  1  qualified by Out_data_vld; always 0 when PARITY=0.
- Out_frame_err  out  1  qualified by Out_data_vld; a checked stop bit sampled low.
- Out_break  out  1  qualified by Out_data_vld; data all zero, parity bit (if any) zero, first stop bit low.
- Out_overrun  out  1  one-cycle pulse: a completed frame was dropped.

Behaviour:
- Reset: clock and reset are fixed as Clk, asynchronous active-high Rst. Rst asserted clears all state at once. State=IDLE; all outputs 0; counters 0; synchroniser/filter preset to 1 (line idle). Reset mid-frame abandons the frame; no output produced.
- Input conditioning: 2-flop synchroniser, then a 3-sample shift register; filtered bit = majority of the 3. Pipeline delay is constant, so sample alignment is unaffected. A single-cycle glitch never reaches the FSM.
- Bit timer: 16-bit baud_cnt. Cleared in IDLE. Counts 0..BAUD_DIV-1 and wraps while not IDLE. Sample strobe when baud_cnt == BAUD_DIV/2-1, i.e. mid-bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: filtered falling edge (prev 1, now 0) -> START; baud_cnt restarts at 0.
  - START: at strobe, filtered 0 -> DATA with bit_cnt=0; filtered 1 -> IDLE (false start, no output).
  - DATA: at each strobe, shift the filtered bit into shreg MSB-down (LSB-first line order). On bit_cnt==DATA_BITS-1 -> PARITY if PARITY!=0, else STOP.
  - PARITY: at strobe, capture the parity bit; parity_err = XOR(data, parity bit) != expected (odd: expect 1, even: expect 0) -> STOP with stop_cnt=0.
  - STOP: at each strobe, OR (~filtered) into frame_err. When stop_cnt==STOP_BITS-1 -> commit, then IDLE. Returning to IDLE at mid-stop lets the next start edge be caught with no dead time.
- Commit (registered, cycle after the final stop strobe):
  - Output register empty, or Out_data_vld && In_ready in that same cycle: load data/flags and set Out_data_vld.
  - Otherwise: discard the new frame, keep the old word, pulse Out_overrun for 1 cycle.
- Handshake: Out_data_vld falls the cycle after Out_data_vld && In_ready unless a commit reloads it in the same cycle. Out_data/flags stay stable while valid and not accepted.
- Width rules: bit_cnt 4 bits; stop_cnt 1 bit. Word assembled right-justified in DATA_BITS.

Decomposition:
- Shared package uart_pkg: state encoding constants (STA_IDLE..STA_STOP), parity mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2), BAUD_DIV lower bound.
- One sub-module: uart_rx_filter (synchroniser + 3-tap majority + falling-edge pulse). Shared with the future transmitter-loopback checker.

Test Plan (BAUD_DIV=16, DATA_BITS=8, PARITY=2, STOP_BITS=1, In_ready=1 unless stated):
- Send 0xA5, parity 0, stop 1 -> Out_data=0xA5, Out_data_vld one cycle, all error flags 0.
- Send 0x3C with parity bit 1 -> Out_data=0x3C, Out_parity_err=1, Out_frame_err=0.
- Send 0x00, parity 0, stop 0 -> Out_frame_err=1, Out_break=1. Next frame 0x55 is received correctly.
- 1-cycle low glitch, then a 4-cycle low pulse on idle line -> no Out_data_vld; FSM back in IDLE.
- In_ready=0, send 0x11 then 0x22 -> Out_data stays 0x11 with valid high; Out_overrun pulses once. Raise In_ready -> valid drops next cycle.
- Assert Rst mid-data-bit 4 of 0xF0, release, send 0x81 -> only 0x81 delivered.
- Repeat the first case with DATA_BITS=7 PARITY=1 STOP_BITS=2, send 0x5A -> Out_data=0x5A. Second stop bit low -> Out_frame_err=1.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: FSM state encoding, parity
// mode codes and the lowest supported clocks-per-bit divider.
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    STA_IDLE   = 3'd0,
    STA_START  = 3'd1,
    STA_DATA   = 3'd2,
    STA_PARITY = 3'd3,
    STA_STOP   = 3'd4
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Below this the mid-bit strobe sits too close to the filter latency.
  localparam int BAUD_DIV_MIN = 16;

endpackage

// File: rtl/uart_rx_filter.sv
// ---------------------------------------------------------------------------
// uart_rx_filter
// Conditions the asynchronous serial line: 2-flop synchroniser, 3-tap
// majority filter and a falling-edge pulse on the filtered line.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset (presets everything to idle 1)
//   rx   in   raw serial line, idle high
//   filt out  majority-filtered line level
//   fall out  one-cycle pulse on a filtered 1->0 transition
// ---------------------------------------------------------------------------
module uart_rx_filter (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic filt,
  output logic fall
);

  logic [1:0] sync;
  logic [2:0] taps;
  logic       filt_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= 2'b11;
      taps      <= 3'b111;
      filt_prev <= 1'b1;
    end else begin
      sync      <= {sync[0], rx};
      taps      <= {taps[1:0], sync[1]};
      filt_prev <= filt;
    end
  end

  // A lone one-cycle glitch occupies only one tap at a time, so it can never
  // win the vote.
  assign filt = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
  assign fall = filt_prev & ~filt;

endmodule

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
// Parametrised UART receiver (5..9 data bits, none/odd/even parity, 1 or 2
// stop bits) with a valid/ready output holding register.
// Ports:
//   Clk             in   system clock
//   Rst             in   asynchronous active-high reset
//   In_rx           in   serial line, idle high, asynchronous to Clk
//   In_ready        in   consumer accepts the current word this cycle
//   Out_data        out  received word, LSB = first bit on the line
//   Out_data_vld    out  word/flags valid, held until accepted
//   Out_parity_err  out  parity mismatch (0 when PARITY = none)
//   Out_frame_err   out  a checked stop bit was sampled low
//   Out_break       out  data zero, parity bit zero, first stop bit low
//   Out_overrun     out  one-cycle pulse: a completed frame was dropped
// ---------------------------------------------------------------------------
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_DIV  = 100,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 In_rx,
  input  logic                 In_ready,
  output logic [DATA_BITS-1:0] Out_data,
  output logic                 Out_data_vld,
  output logic                 Out_parity_err,
  output logic                 Out_frame_err,
  output logic                 Out_break,
  output logic                 Out_overrun
);

  if (CLK_FREQ < 1 || BAUD_DIV < BAUD_DIV_MIN || BAUD_DIV > 65535 ||
      DATA_BITS < 5 || DATA_BITS > 9 || PARITY < PAR_NONE || PARITY > PAR_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_rx_cfg: parameter out of range");
  end

  localparam logic [15:0] BAUD_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BAUD_MID   = 16'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]  BIT_LAST   = 4'(DATA_BITS - 1);
  localparam logic        STOP_LAST  = 1'(STOP_BITS - 1);
  localparam logic        PAR_EXPECT = (PARITY == PAR_ODD);

  logic filt;
  logic fall;

  uart_rx_filter u_filter (
    .clk  (Clk),
    .rst  (Rst),
    .rx   (In_rx),
    .filt (filt),
    .fall (fall)
  );

  state_t                state_q, state_d;
  logic [15:0]           baud_cnt;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  stop1_low_q, stop1_low_d;
  logic                  par_bit_q, par_bit_d;
  logic                  strobe;
  logic                  done;
  logic                  ferr_now;
  logic                  stop1_now;
  logic                  brk_now;

  assign strobe = (state_q != STA_IDLE) && (baud_cnt == BAUD_MID);

  // The final stop strobe folds the live sample in directly so the commit
  // does not need an extra cycle.
  assign ferr_now  = ferr_q | ~filt;
  assign stop1_now = (stop_cnt_q == 1'b0) ? ~filt : stop1_low_q;
  assign brk_now   = (shreg_q == '0) && !par_bit_q && stop1_now;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= STA_IDLE;
      baud_cnt    <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shreg_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      stop1_low_q <= 1'b0;
      par_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shreg_q     <= shreg_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      stop1_low_q <= stop1_low_d;
      par_bit_q   <= par_bit_d;
      if (state_q == STA_IDLE || baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shreg_d     = shreg_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    stop1_low_d = stop1_low_q;
    par_bit_d   = par_bit_q;
    done        = 1'b0;

    unique case (state_q)
      STA_IDLE: begin
        if (fall) begin
          state_d     = STA_START;
          bit_cnt_d   = '0;
          stop_cnt_d  = 1'b0;
          perr_d      = 1'b0;
          ferr_d      = 1'b0;
          stop1_low_d = 1'b0;
          par_bit_d   = 1'b0;
        end
      end
      STA_START: begin
        if (strobe) begin
          state_d   = filt ? STA_IDLE : STA_DATA;
          bit_cnt_d = '0;
        end
      end
      STA_DATA: begin
        if (strobe) begin
          shreg_d = {filt, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = (PARITY != PAR_NONE) ? STA_PARITY : STA_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      STA_PARITY: begin
        if (strobe) begin
          par_bit_d  = filt;
          perr_d     = ((^shreg_q) ^ filt) != PAR_EXPECT;
          stop_cnt_d = 1'b0;
          state_d    = STA_STOP;
        end
      end
      STA_STOP: begin
        if (strobe) begin
          ferr_d      = ferr_now;
          stop1_low_d = stop1_now;
          if (stop_cnt_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = STA_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = STA_IDLE;
    endcase
  end

  // Output holding register: a finished frame loads only if the slot is
  // empty or being drained this very cycle; otherwise it is dropped.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Out_data       <= '0;
      Out_data_vld   <= 1'b0;
      Out_parity_err <= 1'b0;
      Out_frame_err  <= 1'b0;
      Out_break      <= 1'b0;
      Out_overrun    <= 1'b0;
    end else begin
      Out_overrun <= 1'b0;
      if (done) begin
        if (!Out_data_vld || In_ready) begin
          Out_data       <= shreg_q;
          Out_parity_err <= perr_q;
          Out_frame_err  <= ferr_now;
          Out_break      <= brk_now;
          Out_data_vld   <= 1'b1;
        end else begin
          Out_overrun <= 1'b1;
        end
      end else if (Out_data_vld && In_ready) begin
        Out_data_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg
// Two receivers share clock and reset: "a" is 8 data bits / even parity /
// 1 stop, "b" is 7 data bits / odd parity / 2 stops. Frames are queued as
// expected words when sent; a monitor pops them whenever a word is accepted.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

  localparam int BD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx_a, rx_b, rdy_a, rdy_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       vld_a, pe_a, fe_a, brk_a, ovr_a;
  logic       vld_b, pe_b, fe_b, brk_b, ovr_b;

  uart_rx_cfg #(.CLK_FREQ(100000000), .BAUD_DIV(BD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_a (
    .Clk(clk), .Rst(rst), .In_rx(rx_a), .In_ready(rdy_a),
    .Out_data(data_a), .Out_data_vld(vld_a), .Out_parity_err(pe_a),
    .Out_frame_err(fe_a), .Out_break(brk_a), .Out_overrun(ovr_a)
  );

  uart_rx_cfg #(.CLK_FREQ(100000000), .BAUD_DIV(BD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
    .Clk(clk), .Rst(rst), .In_rx(rx_b), .In_ready(rdy_b),
    .Out_data(data_b), .Out_data_vld(vld_b), .Out_parity_err(pe_b),
    .Out_frame_err(fe_b), .Out_break(brk_b), .Out_overrun(ovr_b)
  );

  int checks   = 0;
  int failures = 0;
  logic [11:0] q_a[$];
  logic [11:0] q_b[$];
  int ovr_seen_a = 0, ovr_seen_b = 0, exp_ovr_a = 0, exp_ovr_b = 0;
  int vld_cyc_a = 0;
  bit rand_done;

  // Expected word {break, frame_err, parity_err, data[8:0]} from frame rules.
  function automatic logic [11:0] model(input logic [8:0] d, input int nbits, input int pmode,
                                        input logic pbit, input logic [1:0] stops, input int nstops);
    logic [9:0] mask;
    logic [8:0] m;
    int ones;
    logic perr, ferr, brk;
    mask = (10'd1 << nbits) - 10'd1;
    m    = d & mask[8:0];
    ones = $countones(m) + ((pmode != 0) ? int'(pbit) : 0);
    perr = (pmode == 1) ? (ones % 2 == 0) : (pmode == 2) ? (ones % 2 == 1) : 1'b0;
    ferr = 1'b0;
    for (int i = 0; i < nstops; i++) if (!stops[i]) ferr = 1'b1;
    brk  = (m == 9'd0) && (pmode == 0 || !pbit) && !stops[0];
    return {brk, ferr, perr, m};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic line(input int which, input logic v);
    if (which == 0) rx_a = v; else rx_b = v;
    repeat (BD) @(negedge clk);
  endtask

  task automatic send(input int which, input logic [8:0] d, input logic pbit,
                      input logic [1:0] stops, input bit push);
    int nb = (which == 0) ? 8 : 7;
    int pm = (which == 0) ? 2 : 1;
    int ns = (which == 0) ? 1 : 2;
    if (push) begin
      if (which == 0) q_a.push_back(model(d, nb, pm, pbit, stops, ns));
      else            q_b.push_back(model(d, nb, pm, pbit, stops, ns));
    end
    line(which, 1'b0);
    for (int i = 0; i < nb; i++) line(which, d[i]);
    line(which, pbit);
    for (int i = 0; i < ns; i++) line(which, stops[i]);
    repeat (3) line(which, 1'b1);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  function automatic logic odd_par(input logic [6:0] d);
    return ~(^d);
  endfunction

  task automatic monitor();
    logic [11:0] exp;
    logic [11:0] got;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (vld_a) vld_cyc_a++;
        if (ovr_a) ovr_seen_a++;
        if (ovr_b) ovr_seen_b++;
        if (vld_a && rdy_a) begin
          got = {brk_a, fe_a, pe_a, 1'b0, data_a};
          if (q_a.size() == 0) chk("word_a_unexpected", {20'd0, got}, 32'hFFFF_FFFF);
          else begin
            exp = q_a.pop_front();
            chk("word_a", {20'd0, got}, {20'd0, exp});
          end
        end
        if (vld_b && rdy_b) begin
          got = {brk_b, fe_b, pe_b, 2'b00, data_b};
          if (q_b.size() == 0) chk("word_b_unexpected", {20'd0, got}, 32'hFFFF_FFFF);
          else begin
            exp = q_b.pop_front();
            chk("word_b", {20'd0, got}, {20'd0, exp});
          end
        end
      end
    end
  endtask

  initial begin
    int v0;
    logic [7:0] da;
    logic [6:0] db;
    logic pa;
    logic [1:0] st;

    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    fork monitor(); join_none
    repeat (4) @(negedge clk);
    chk("reset_a", {26'd0, vld_a, pe_a, fe_a, brk_a, ovr_a, |data_a}, 32'd0);
    chk("reset_b", {26'd0, vld_b, pe_b, fe_b, brk_b, ovr_b, |data_b}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);

    // Clean frame: exactly one valid cycle with ready held high.
    v0 = vld_cyc_a;
    send(0, 9'h0A5, 1'b0, 2'b11, 1'b1);
    chk("a5_vld_cycles", 32'(vld_cyc_a - v0), 32'd1);
    send(0, 9'h03C, 1'b1, 2'b11, 1'b1);
    send(0, 9'h000, 1'b0, 2'b00, 1'b1);
    send(0, 9'h055, 1'b0, 2'b11, 1'b1);

    // Glitch and short pulse on an idle line produce nothing.
    v0 = vld_cyc_a;
    rx_a = 1'b0; @(negedge clk); rx_a = 1'b1;
    repeat (20) @(negedge clk);
    rx_a = 1'b0; repeat (4) @(negedge clk); rx_a = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_no_output", 32'(vld_cyc_a - v0), 32'd0);
    send(0, 9'h0C3, even_par(8'hC3), 2'b11, 1'b1);

    // Overrun: second frame dropped while first is held.
    @(posedge clk); #1 rdy_a = 1'b0;
    v0 = ovr_seen_a;
    send(0, 9'h011, even_par(8'h11), 2'b11, 1'b1);
    send(0, 9'h022, even_par(8'h22), 2'b11, 1'b0);
    exp_ovr_a++;
    chk("ovr_hold", {23'd0, vld_a, data_a}, {23'd0, 1'b1, 8'h11});
    chk("ovr_pulse_once", 32'(ovr_seen_a - v0), 32'd1);
    @(posedge clk); #1 rdy_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("vld_drop_after_accept", {31'd0, vld_a}, 32'd0);

    // Reset in the middle of data bit 4 of 0xF0 abandons the frame.
    chk("queue_a_empty_pre_rst", q_a.size(), 32'd0);
    line(0, 1'b0);
    for (int i = 0; i < 4; i++) line(0, 1'b0);
    rx_a = 1'b1;
    repeat (BD / 2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_outputs", {29'd0, vld_a, ovr_a, |data_a}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3 * BD) @(negedge clk);
    send(0, 9'h081, even_par(8'h81), 2'b11, 1'b1);

    // 7-bit odd-parity two-stop receiver.
    send(1, 9'h05A, odd_par(7'h5A), 2'b11, 1'b1);
    send(1, 9'h05A, odd_par(7'h5A), 2'b01, 1'b1);
    send(1, 9'h000, 1'b0, 2'b10, 1'b1);

    // Random frames with randomly stalling consumers.
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          da = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 7) == 0) da = 8'h00;
          pa = even_par(da) ^ ($urandom_range(0, 3) == 0);
          st = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b11;
          send(0, {1'b0, da}, pa, st, 1'b1);
          db = 7'($urandom_range(0, 127));
          if ($urandom_range(0, 7) == 0) db = 7'h00;
          pa = odd_par(db) ^ ($urandom_range(0, 3) == 0);
          st = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 0) st = 2'b11;
          send(1, {2'b00, db}, pa, st, 1'b1);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          rdy_a = 1'($urandom_range(0, 1));
          rdy_b = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1 rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (100) @(negedge clk);

    chk("queue_a_drained", q_a.size(), 32'd0);
    chk("queue_b_drained", q_b.size(), 32'd0);
    chk("overrun_count_a", ovr_seen_a, exp_ovr_a);
    chk("overrun_count_b", ovr_seen_b, exp_ovr_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
